// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the iterative multiplier
package mul_pkg;

    localparam int XLEN     = 32;
    localparam int MUL_ITER = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } mul_state_e;

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] x);
        return ~x + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/cla.sv
// rtl/cla.sv - 32-bit carry-lookahead adder, 4-bit lookahead groups
module cla
    import mul_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_cin,
    output logic [XLEN-1:0] o_sum,
    output logic            o_carry
);

    localparam int GROUPS = XLEN / 4;

    logic [XLEN-1:0]   gen;
    logic [XLEN-1:0]   prop;
    logic [XLEN-1:0]   c_bit;
    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;

    assign gen  = i_a & i_b;
    assign prop = i_a ^ i_b;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int i = 0; i < GROUPS; i++) begin
            grp_g[i] = gen[4*i+3]
                     | (prop[4*i+3] & gen[4*i+2])
                     | (prop[4*i+3] & prop[4*i+2] & gen[4*i+1])
                     | (prop[4*i+3] & prop[4*i+2] & prop[4*i+1] & gen[4*i]);
            grp_p[i] = &prop[4*i +: 4];
        end
    end

    // Group carry ripples across groups; bit carries inside a group are flat lookahead terms.
    always_comb begin
        logic cy;
        cy    = i_cin;
        c_bit = '0;
        for (int i = 0; i < GROUPS; i++) begin
            c_bit[4*i]   = cy;
            c_bit[4*i+1] = gen[4*i] | (prop[4*i] & cy);
            c_bit[4*i+2] = gen[4*i+1]
                         | (prop[4*i+1] & gen[4*i])
                         | (prop[4*i+1] & prop[4*i] & cy);
            c_bit[4*i+3] = gen[4*i+2]
                         | (prop[4*i+2] & gen[4*i+1])
                         | (prop[4*i+2] & prop[4*i+1] & gen[4*i])
                         | (prop[4*i+2] & prop[4*i+1] & prop[4*i] & cy);
            cy = grp_g[i] | (grp_p[i] & cy);
        end
        o_carry = cy;
    end

    assign o_sum = prop ^ c_bit;

endmodule

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - radix-2 shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
module seq_mul
    import mul_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_data_a,
    input  logic [XLEN-1:0] i_data_b,
    output logic            o_ready,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    mul_state_e        state;
    mul_op_e           op_q;
    logic [XLEN-1:0]   m_q;
    logic [2*XLEN-1:0] p_q;
    logic [4:0]        cnt_q;
    logic              neg_q;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   add_sum;
    logic              add_carry;
    logic [2*XLEN-1:0] p_final;

    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        case (mul_op_e'(i_op))
            OP_MULH: begin
                a_neg = i_data_a[XLEN-1];
                b_neg = i_data_b[XLEN-1];
            end
            OP_MULHSU: a_neg = i_data_a[XLEN-1];
            default: ;
        endcase
        a_mag = a_neg ? twos_neg(i_data_a) : i_data_a;
        b_mag = b_neg ? twos_neg(i_data_b) : i_data_b;
    end

    cla u_cla (
        .i_a     (p_q[2*XLEN-1:XLEN]),
        .i_b     (m_q),
        .i_cin   (1'b0),
        .o_sum   (add_sum),
        .o_carry (add_carry)
    );

    // The result register is loaded from the corrected product in the same edge as P.
    assign p_final = neg_q ? (~p_q + 64'd1) : p_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_MUL;
            m_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            o_ready  <= 1'b1;
            o_done   <= 1'b0;
            o_result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        op_q    <= mul_op_e'(i_op);
                        m_q     <= a_mag;
                        p_q     <= {{XLEN{1'b0}}, b_mag};
                        neg_q   <= a_neg ^ b_neg;
                        cnt_q   <= '0;
                        o_ready <= 1'b0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (p_q[0]) begin
                        p_q <= {add_carry, add_sum, p_q[XLEN-1:1]};
                    end else begin
                        p_q <= {1'b0, p_q[2*XLEN-1:1]};
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(MUL_ITER - 1)) begin
                        state <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    p_q      <= p_final;
                    o_result <= (op_q == OP_MUL) ? p_final[XLEN-1:0]
                                                 : p_final[2*XLEN-1:XLEN];
                    o_done   <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    o_done  <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    o_done  <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - randomized self-checking bench for seq_mul against a product model
module tb_seq_mul;
    import mul_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_data_a = '0;
    logic [31:0] i_data_b = '0;
    logic        o_ready;
    logic        o_done;
    logic [31:0] o_result;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mul dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_data_a (i_data_a),
        .i_data_b (i_data_b),
        .o_ready  (o_ready),
        .o_done   (o_done),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ae, be, pr;
        ae = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
        be = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        pr = ae * be;
        return (op == OP_MUL) ? pr[31:0] : pr[63:32];
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        while (!o_ready && w < 50) begin
            tick();
            w++;
        end
        check("ready_before_issue", {31'b0, o_ready}, 32'd1);
        i_op     = op;
        i_data_a = a;
        i_data_b = b;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        i_op     = 2'($urandom);
        i_data_a = $urandom;
        i_data_b = $urandom;
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit pulse);
        logic [31:0] exp, res_at_done;
        int done_cyc, ndone;
        bit rdy_bad;
        exp = ref_mul(op, a, b);
        issue(op, a, b);
        done_cyc = 0; ndone = 0; rdy_bad = 0; res_at_done = '0;
        for (int c = 1; c <= 40; c++) begin
            if (o_done) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc    = c;
                    res_at_done = o_result;
                end
            end
            if (c <= 34 && o_ready) rdy_bad = 1;
            if (c == 35 && !o_ready) rdy_bad = 1;
            if (pulse && (c == 5 || c == 34)) begin
                i_start  = 1'b1;
                i_op     = 2'($urandom);
                i_data_a = $urandom;
                i_data_b = $urandom;
            end else begin
                i_start = 1'b0;
            end
            tick();
        end
        i_start = 1'b0;
        check({tag, "_latency"}, 32'(done_cyc), 32'd34);
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
        check({tag, "_ready_profile"}, {31'b0, rdy_bad}, 32'd0);
        check({tag, "_result"}, res_at_done, exp);
        check({tag, "_held"}, o_result, exp);
    endtask

    initial begin
        logic [31:0] corners [5];
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        int          nd;
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        check("reset_ready", {31'b0, o_ready}, 32'd1);
        check("reset_done", {31'b0, o_done}, 32'd0);
        check("reset_result", o_result, 32'd0);

        run_and_check("mul_7x6", OP_MUL, 32'd7, 32'd6, 1'b0);
        check("mul_7x6_const", o_result, 32'h0000_002A);
        run_and_check("mulhu_m1", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("mulhu_m1_const", o_result, 32'hFFFF_FFFE);
        run_and_check("mulh_m1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("mulh_m1_const", o_result, 32'h0000_0000);
        run_and_check("mul_m1", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("mul_m1_const", o_result, 32'h0000_0001);
        run_and_check("mulhsu_m1x2", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("mulhsu_m1x2_const", o_result, 32'hFFFF_FFFF);
        run_and_check("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("mulh_min_const", o_result, 32'h4000_0000);
        run_and_check("mulh_zero", OP_MULH, 32'h0, 32'h1234_5678, 1'b0);
        check("mulh_zero_const", o_result, 32'h0000_0000);

        run_and_check("ignored_start", OP_MULHSU, 32'h8765_4321, 32'hDEAD_BEEF, 1'b1);
        run_and_check("after_ignored", OP_MUL, 32'h0001_0003, 32'h0000_0101, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom);
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            run_and_check($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
        end

        issue(OP_MULH, 32'hF00D_1234, 32'h0BAD_F00D);
        for (int c = 1; c < 10; c++) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_ready", {31'b0, o_ready}, 32'd1);
        check("midrst_result", o_result, 32'd0);
        check("midrst_done", {31'b0, o_done}, 32'd0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_done) nd++;
            tick();
        end
        check("midrst_no_done", 32'(nd), 32'd0);
        run_and_check("mul_3x5", OP_MUL, 32'd3, 32'd5, 1'b0);
        check("mul_3x5_const", o_result, 32'h0000_000F);

        i_op     = OP_MULHU;
        i_data_a = 32'hFFFF_FFFF;
        i_data_b = 32'hFFFF_FFFF;
        i_rst    = 1'b1;
        i_start  = 1'b1;
        tick();
        i_rst    = 1'b0;
        i_start  = 1'b0;
        check("rst_start_ready", {31'b0, o_ready}, 32'd1);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_done || !o_ready) nd++;
            tick();
        end
        check("rst_start_dropped", 32'(nd), 32'd0);
        check("rst_start_result", o_result, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
